bp_me_stream_lock_scheduler: RTL
================================

Name: bp_me_stream_lock_scheduler

Overview:
- Schedules a BedRock stream crossbar (N requesters to M devices, e.g. {IO, BE UCE, FE UCE} to {LOOPBACK, IO, L2, CLINT, CFG}).
- Holds one round-robin arbiter per sink. Each arbiter locks its grant for the full multi-beat message, so beats from different sources never interleave at a sink.
- Drives the per-sink source select for the external header/data mux and generates per-source ready_and.

Parameters:
- num_source_p, 3, number of requesting sources.
- num_sink_p, 5, number of destination devices.
- len_width_p, 3, width of the per-message beat count field (beats minus one; max 2^len_width_p beats).
- lg_num_source_lp, derived `BSG_SAFE_CLOG2(num_source_p)`, select width.
- lg_num_sink_lp, derived `BSG_SAFE_CLOG2(num_sink_p)`, destination width.

Ports:
- clk_i  in  1  single clock.
- reset_i  in  1  asynchronous, active-high reset.
- src_v_i  in  num_source_p  source beat valid.
- src_dst_i  in  num_source_p*lg_num_sink_lp  destination sink index; stable while src_v_i is high.
- src_len_i  in  num_source_p*len_width_p  beats minus one; sampled on the first beat only.
- src_ready_and_o  out  num_source_p  beat accepted when src_v_i is also high.
- sink_v_o  out  num_sink_p  valid toward the sink.
- sink_ready_and_i  in  num_sink_p  sink ready.
- sink_sel_o  out  num_sink_p*lg_num_source_lp  granted source index per sink.
- sink_locked_o  out  num_sink_p  sink is mid-message.
- bad_dst_o  out  num_source_p  src_v_i with src_dst_i >= num_sink_p (combinational).

Behaviour:
- Handshake: a beat transfers on src_v_i[s] & src_ready_and_o[s] (equal to sink_v_o[d] & sink_ready_and_i[d]).
- Per-sink state:
  - rr_ptr: last winner. Resets to num_source_p-1, so source 0 has priority first.
  - state: IDLE or LOCKED.
  - owner: lg_num_source_lp bits.
  - cnt: len_width_p bits, remaining beats.
- IDLE:
  - Requesters are sources with src_v_i & (src_dst_i==sink).
  - Combinational round-robin picks the first requester after rr_ptr, wrapping.
  - sink_sel_o = winner; sink_v_o = 1 if any requester, else 0 with sink_sel_o = 0.
  - No handshake: no state change. Grant may move next cycle; only a handshake commits.
  - Handshake with src_len==0: stay IDLE, rr_ptr <= winner.
  - Handshake with src_len>0: go LOCKED, owner <= winner, cnt <= src_len-1.
- LOCKED:
  - sink_sel_o = owner; sink_v_o = src_v_i[owner]. Other sources get no ready.
  - Handshake with cnt!=0: cnt <= cnt-1.
  - Handshake with cnt==0: go IDLE, rr_ptr <= owner.
  - Owner src_v_i low (bubble): hold the lock, no timeout.
- Back-to-back: a new message arbitrates in the cycle after the last beat, with zero bubble cycles beyond that. The same source may win again only if it is the sole requester.
- A source is routed only to its src_dst_i sink. The src_ready_and_o rows are mutually exclusive per source by construction.
- Out-of-range src_dst_i: never granted, src_ready_and_o = 0, bad_dst_o high. Other traffic is unaffected.
- sink_locked_o = (state==LOCKED).
- Reset asserted (async), including mid-message:
  - All sinks go IDLE, cnt = 0, owner = 0, rr_ptr = num_source_p-1.
  - src_ready_and_o, sink_v_o, sink_locked_o and sink_sel_o are forced to 0 while reset_i is high.
  - A partial message is discarded. Upstream is reset together with this block.
- Latency: grant and ready are combinational from valid/ready in the same cycle. State registers update on posedge clk_i.

Decomposition:
- bp_me_pkg: enum bp_me_stream_lock_state_e {e_lock_idle, e_lock_locked}.
- Sub-module bp_me_stream_lock_arb_sink:
  - One instance per sink, in a generate loop.
  - Contains the rr_ptr/state/owner/cnt registers and a bsg_arb_round_robin-style priority picker.
  - Inputs: request vector, len vector, ready. Outputs: sel, v, grant one-hot, locked.
- Top level: request decode (dst compare), grant-to-source transpose (OR-reduce over sinks), bad_dst_o.

Test Plan:
- Out of reset, src 0,1,2 all valid to sink 2, len=0, sink always ready -> grants 0,1,2,0 on consecutive cycles; sink_locked_o stays 0.
- src1 sends len=3 to sink 2 while src0 is also valid to sink 2 -> sink_sel_o=1 for 4 handshakes; src_ready_and_o[0]=0 throughout; src0 granted on the 5th cycle.
- Locked src1, sink_ready_and_i toggled 1,0,1,0 and src_v_i[1] dropped one cycle -> cnt decrements only on handshakes; exactly 4 beats accepted; no interleave.
- src0 to sink 1 and src2 to sink 4 concurrently, len=1 each -> both progress in parallel, 2 beats each in 2 cycles.
- src1 src_dst_i=6 -> bad_dst_o[1]=1, src_ready_and_o[1]=0; src0 traffic to sink 0 unaffected.
- Reset asserted after beat 2 of a len=3 message -> outputs 0 immediately (async); after release, sink IDLE with rr_ptr=2, and src0 wins a 3-way contention.

Source files
------------

// File: rtl/bp_me_stream_lock_scheduler_pkg.sv
// rtl/bp_me_stream_lock_scheduler_pkg.sv - shared types and width helper for the stream lock scheduler
package bp_me_stream_lock_scheduler_pkg;

  typedef enum logic {
    e_lock_idle,
    e_lock_locked
  } bp_me_stream_lock_state_e;

  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bp_me_stream_lock_scheduler_if.sv
// rtl/bp_me_stream_lock_scheduler_if.sv - source/sink handshake bundle of the stream lock scheduler
interface bp_me_stream_lock_scheduler_if
  import bp_me_stream_lock_scheduler_pkg::*;
#(
  parameter int num_source_p = 3,
  parameter int num_sink_p   = 5,
  parameter int len_width_p  = 3
) ();

  localparam int lg_num_source_lp = safe_clog2(num_source_p);
  localparam int lg_num_sink_lp   = safe_clog2(num_sink_p);

  logic [num_source_p-1:0]                  src_v_i;
  logic [num_source_p*lg_num_sink_lp-1:0]   src_dst_i;
  logic [num_source_p*len_width_p-1:0]      src_len_i;
  logic [num_source_p-1:0]                  src_ready_and_o;
  logic [num_sink_p-1:0]                    sink_v_o;
  logic [num_sink_p-1:0]                    sink_ready_and_i;
  logic [num_sink_p*lg_num_source_lp-1:0]   sink_sel_o;
  logic [num_sink_p-1:0]                    sink_locked_o;
  logic [num_source_p-1:0]                  bad_dst_o;

  modport master (
    output src_v_i, src_dst_i, src_len_i, sink_ready_and_i,
    input  src_ready_and_o, sink_v_o, sink_sel_o, sink_locked_o, bad_dst_o
  );

  modport slave (
    input  src_v_i, src_dst_i, src_len_i, sink_ready_and_i,
    output src_ready_and_o, sink_v_o, sink_sel_o, sink_locked_o, bad_dst_o
  );

endinterface

// File: rtl/bp_me_stream_lock_scheduler_arb_sink.sv
// rtl/bp_me_stream_lock_scheduler_arb_sink.sv - per-sink round-robin arbiter that locks for a whole message
module bp_me_stream_lock_arb_sink
  import bp_me_stream_lock_scheduler_pkg::*;
#(
  parameter int num_source_p     = 3,
  parameter int len_width_p      = 3,
  parameter int lg_num_source_lp = 2
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [num_source_p-1:0]             req_i,
  input  logic [num_source_p*len_width_p-1:0] len_i,
  input  logic                                ready_i,
  output logic [lg_num_source_lp-1:0]         sel_o,
  output logic                                v_o,
  output logic [num_source_p-1:0]             grant_o,
  output logic                                locked_o
);

  bp_me_stream_lock_state_e      state_q;
  logic [lg_num_source_lp-1:0]   owner_q;
  logic [lg_num_source_lp-1:0]   rr_ptr_q;
  logic [len_width_p-1:0]        cnt_q;

  logic [lg_num_source_lp-1:0]   winner;
  logic                          any_req;
  logic                          hs;
  logic [len_width_p-1:0]        win_len;
  int                            idx;

  // Scan starts one past the last winner so it gets lowest priority next time.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 1; i <= num_source_p; i++) begin
      idx = (int'(rr_ptr_q) + i) % num_source_p;
      if (!any_req && req_i[idx]) begin
        any_req = 1'b1;
        winner  = lg_num_source_lp'(idx);
      end
    end
  end

  always_comb begin
    sel_o = '0;
    v_o   = 1'b0;
    if (!reset_i) begin
      if (state_q == e_lock_locked) begin
        sel_o = owner_q;
        v_o   = req_i[owner_q];
      end else begin
        sel_o = winner;
        v_o   = any_req;
      end
    end
  end

  assign hs       = v_o & ready_i;
  assign win_len  = len_i[int'(winner)*len_width_p +: len_width_p];
  assign locked_o = !reset_i && (state_q == e_lock_locked);

  always_comb begin
    grant_o = '0;
    if (hs) grant_o[sel_o] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= e_lock_idle;
      owner_q  <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= lg_num_source_lp'(num_source_p - 1);
    end else begin
      case (state_q)
        e_lock_idle: begin
          if (hs) begin
            if (win_len == '0) begin
              rr_ptr_q <= winner;
            end else begin
              state_q <= e_lock_locked;
              owner_q <= winner;
              cnt_q   <= win_len - 1'b1;
            end
          end
        end
        e_lock_locked: begin
          if (hs) begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end else begin
              state_q  <= e_lock_idle;
              rr_ptr_q <= owner_q;
            end
          end
        end
        default: state_q <= e_lock_idle;
      endcase
    end
  end

endmodule

// File: rtl/bp_me_stream_lock_scheduler.sv
// rtl/bp_me_stream_lock_scheduler.sv - N-source to M-sink stream crossbar scheduler with per-sink message locks
module bp_me_stream_lock_scheduler
  import bp_me_stream_lock_scheduler_pkg::*;
#(
  parameter int num_source_p = 3,
  parameter int num_sink_p   = 5,
  parameter int len_width_p  = 3
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  bp_me_stream_lock_scheduler_if.slave    io
);

  localparam int lg_num_source_lp = safe_clog2(num_source_p);
  localparam int lg_num_sink_lp   = safe_clog2(num_sink_p);

  logic [num_sink_p-1:0][num_source_p-1:0]     req;
  logic [num_sink_p-1:0][num_source_p-1:0]     grant;
  logic [num_sink_p-1:0][lg_num_source_lp-1:0] sel;
  logic [num_sink_p-1:0]                       sink_v;
  logic [num_sink_p-1:0]                       locked;

  // Out-of-range destinations match no sink, so they are never granted.
  always_comb begin
    req           = '0;
    io.bad_dst_o  = '0;
    for (int s = 0; s < num_source_p; s++) begin
      for (int d = 0; d < num_sink_p; d++) begin
        req[d][s] = io.src_v_i[s]
                  && (io.src_dst_i[s*lg_num_sink_lp +: lg_num_sink_lp] == lg_num_sink_lp'(d));
      end
      io.bad_dst_o[s] = io.src_v_i[s]
                      && (32'(io.src_dst_i[s*lg_num_sink_lp +: lg_num_sink_lp]) >= 32'(num_sink_p));
    end
  end

  for (genvar d = 0; d < num_sink_p; d++) begin : g_sink
    bp_me_stream_lock_arb_sink #(
      .num_source_p     (num_source_p),
      .len_width_p      (len_width_p),
      .lg_num_source_lp (lg_num_source_lp)
    ) u_arb (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .req_i    (req[d]),
      .len_i    (io.src_len_i),
      .ready_i  (io.sink_ready_and_i[d]),
      .sel_o    (sel[d]),
      .v_o      (sink_v[d]),
      .grant_o  (grant[d]),
      .locked_o (locked[d])
    );
  end

  always_comb begin
    io.src_ready_and_o = '0;
    for (int d = 0; d < num_sink_p; d++) begin
      io.src_ready_and_o = io.src_ready_and_o | grant[d];
    end
  end

  assign io.sink_sel_o    = sel;
  assign io.sink_v_o      = sink_v;
  assign io.sink_locked_o = locked;

endmodule
